// File: rtl/ttt_pkg.sv
// ttt_pkg: shared encodings for the tic-tac-toe move sequencer and game controller.
//   - cell encoding (EMPTY/PX/PO), winner encoding (NONE/WX/WO/DRAW)
//   - sequencer state enum
//   - WIN_LINES: 8 lines of 3 cell indices. Entry [l][0..2] holds the cells of line l
//     in scan order: rows 0-2, columns 0-2, diagonal, anti-diagonal.
package ttt_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] PX    = 2'b01;
    localparam logic [1:0] PO    = 2'b10;

    localparam logic [1:0] NONE  = 2'b00;
    localparam logic [1:0] WX    = 2'b01;
    localparam logic [1:0] WO    = 2'b10;
    localparam logic [1:0] DRAW  = 2'b11;

    localparam int unsigned NUM_LINES = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Packed so it can be indexed by a run-time line number; line 0 is the last element.
    localparam logic [7:0][2:0][3:0] WIN_LINES = {
        {4'd6, 4'd4, 4'd2},  // 7: anti-diagonal
        {4'd8, 4'd4, 4'd0},  // 6: diagonal
        {4'd8, 4'd5, 4'd2},  // 5: column 2
        {4'd7, 4'd4, 4'd1},  // 4: column 1
        {4'd6, 4'd3, 4'd0},  // 3: column 0
        {4'd8, 4'd7, 4'd6},  // 2: row 2
        {4'd5, 4'd4, 4'd3},  // 1: row 1
        {4'd2, 4'd1, 4'd0}   // 0: row 0
    };

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == PX) ? PO : PX;
    endfunction

endpackage

// File: rtl/line_checker.sv
// line_checker: combinational test of one win line on the board.
//   board_i  [17:0] board, cell i at [2i+1:2i]
//   line_i   [2:0]  line index into WIN_LINES
//   hit_o           all three cells equal and non-empty
//   player_o [1:0]  owner of the line on a hit, EMPTY otherwise
module line_checker
    import ttt_pkg::*;
(
    input  logic [17:0] board_i,
    input  logic [2:0]  line_i,
    output logic        hit_o,
    output logic [1:0]  player_o
);

    logic [1:0] c0, c1, c2;

    always_comb begin
        c0 = board_i[{WIN_LINES[line_i][0], 1'b0} +: 2];
        c1 = board_i[{WIN_LINES[line_i][1], 1'b0} +: 2];
        c2 = board_i[{WIN_LINES[line_i][2], 1'b0} +: 2];
        hit_o    = (c0 != EMPTY) && (c0 == c1) && (c1 == c2);
        player_o = hit_o ? c0 : EMPTY;
    end

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: accepts player moves over valid/ready, validates them, keeps the board,
// scans the 8 win lines one per cycle after each move and reports the game result.
// All state updates on the rising edge of ph2; every output is a register.
//   ph1, ph2    two-phase clocks (ph1 is not needed by this block's logic)
//   reset       synchronous, active-low
//   newGame     synchronous restart, same effect as reset
//   moveValid   move request; moveCell [3:0] target cell 0..8
//   moveReady   block accepts a move this cycle (IDLE only)
//   moveAck     one-cycle pulse: move accepted
//   moveErr     one-cycle pulse: move rejected (occupied or out of range)
//   turn [1:0]  player to move; gBoard [17:0] board; gameIsDone, winner [1:0] result
module move_sequencer
    import ttt_pkg::*;
#(
    parameter logic [1:0]  FIRST_PLAYER = 2'b01,
    parameter int unsigned CELLS        = 9
) (
    input  logic         ph1,
    input  logic         ph2,
    input  logic         reset,
    input  logic         newGame,
    input  logic         moveValid,
    input  logic [3:0]   moveCell,
    output logic         moveReady,
    output logic         moveAck,
    output logic         moveErr,
    output logic [1:0]   turn,
    output logic [17:0]  gBoard,
    output logic         gameIsDone,
    output logic [1:0]   winner
);

    logic unused_ph1;
    assign unused_ph1 = ph1;

    state_t      state_q;
    logic [2:0]  line_q;
    logic [17:0] board_q;
    logic [1:0]  turn_q;
    logic [1:0]  winner_q;
    logic        done_q;
    logic        ready_q;
    logic        ack_q;
    logic        err_q;

    logic        cell_free;
    logic        board_full;
    logic [17:0] board_written;
    logic        line_hit;
    logic [1:0]  line_player;

    line_checker u_line_checker (
        .board_i  (board_q),
        .line_i   (line_q),
        .hit_o    (line_hit),
        .player_o (line_player)
    );

    // Legality and the post-move board. Out-of-range cells never match, so cell_free
    // stays low for them.
    always_comb begin
        cell_free     = 1'b0;
        board_full    = 1'b1;
        board_written = board_q;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (board_q[2*i +: 2] == EMPTY) begin
                board_full = 1'b0;
            end
            if (32'(moveCell) == i) begin
                cell_free             = (board_q[2*i +: 2] == EMPTY);
                board_written[2*i +: 2] = turn_q;
            end
        end
    end

    always_ff @(posedge ph2) begin
        if (!reset || newGame) begin
            state_q  <= IDLE;
            line_q   <= 3'd0;
            board_q  <= '0;
            turn_q   <= FIRST_PLAYER;
            winner_q <= NONE;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // ready_q is always high here, so moveValid alone is the handshake.
                    if (moveValid) begin
                        if (cell_free) begin
                            board_q <= board_written;
                            ack_q   <= 1'b1;
                            ready_q <= 1'b0;
                            line_q  <= 3'd0;
                            state_q <= SCAN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (line_hit) begin
                        winner_q <= line_player;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else if (line_q == 3'(NUM_LINES - 1)) begin
                        if (board_full) begin
                            winner_q <= DRAW;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            turn_q  <= other_player(turn_q);
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        line_q <= line_q + 3'd1;
                    end
                end
                DONE: begin
                    // Result holds until newGame or reset.
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign moveReady  = ready_q;
    assign moveAck    = ack_q;
    assign moveErr    = err_q;
    assign turn       = turn_q;
    assign gBoard     = board_q;
    assign gameIsDone = done_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the game rules.
module tb_move_sequencer;

    logic        ph1 = 1'b0;
    logic        ph2 = 1'b0;
    logic        reset, newGame, moveValid;
    logic [3:0]  moveCell;
    logic        moveReady, moveAck, moveErr, gameIsDone;
    logic [1:0]  turn, winner;
    logic [17:0] gBoard;

    move_sequencer #(
        .FIRST_PLAYER (2'b01),
        .CELLS        (9)
    ) dut (
        .ph1        (ph1),
        .ph2        (ph2),
        .reset      (reset),
        .newGame    (newGame),
        .moveValid  (moveValid),
        .moveCell   (moveCell),
        .moveReady  (moveReady),
        .moveAck    (moveAck),
        .moveErr    (moveErr),
        .turn       (turn),
        .gBoard     (gBoard),
        .gameIsDone (gameIsDone),
        .winner     (winner)
    );

    initial begin
        forever begin
            #1 ph1 = 1'b1;
            #4 ph1 = 1'b0;
            #1 ph2 = 1'b1;
            #4 ph2 = 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: game rules plus the time a result takes to appear.
    int lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
                         '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
                         '{0, 4, 8}, '{2, 4, 6}};
    int m_cells [9];
    int m_turn = 1, m_winner = 0, m_busy = 0, m_pend_winner = 0;
    bit m_done = 0, m_ready = 1, m_ack = 0, m_err = 0, m_pend_end = 0;

    function automatic int first_win();
        for (int k = 0; k < 8; k++) begin
            int a = m_cells[lines[k][0]];
            if (a != 0 && a == m_cells[lines[k][1]] && a == m_cells[lines[k][2]]) return k;
        end
        return -1;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < 9; i++) if (m_cells[i] == 0) return 0;
        return 1;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = m_cells[i][1:0];
        return b;
    endfunction

    task automatic model_edge(input logic r, input logic ng, input logic mv, input logic [3:0] c);
        int ci, k;
        ci = int'(c);
        if (!r || ng) begin
            for (int i = 0; i < 9; i++) m_cells[i] = 0;
            m_turn = 1; m_winner = 0; m_done = 0; m_ready = 1;
            m_ack = 0; m_err = 0; m_busy = 0;
        end else begin
            m_ack = 0;
            m_err = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    if (m_pend_end) begin
                        m_done   = 1;
                        m_winner = m_pend_winner;
                    end else begin
                        m_turn  = 3 - m_turn;
                        m_ready = 1;
                    end
                end
            end else if (!m_done && mv) begin
                if (ci <= 8 && m_cells[ci] == 0) begin
                    m_cells[ci] = m_turn;
                    m_ack   = 1;
                    m_ready = 0;
                    k = first_win();
                    if (k >= 0) begin
                        m_busy        = k + 1;
                        m_pend_end    = 1;
                        m_pend_winner = m_cells[lines[k][0]];
                    end else begin
                        m_busy        = 8;
                        m_pend_end    = model_full();
                        m_pend_winner = 3;
                    end
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic ng, input logic mv, input logic [3:0] c);
        reset = r; newGame = ng; moveValid = mv; moveCell = c;
        model_edge(r, ng, mv, c);
        @(posedge ph2);
        #1;
        check("moveReady",  32'(moveReady),  32'(m_ready));
        check("moveAck",    32'(moveAck),    32'(m_ack));
        check("moveErr",    32'(moveErr),    32'(m_err));
        check("turn",       32'(turn),       32'(m_turn));
        check("gBoard",     32'(gBoard),     32'(model_board()));
        check("gameIsDone", 32'(gameIsDone), 32'(m_done));
        check("winner",     32'(winner),     32'(m_winner));
    endtask

    task automatic settle();
        int n = 0;
        while (m_busy > 0 && n < 20) begin
            cycle(1'b1, 1'b0, 1'b0, 4'd0);
            n++;
        end
    endtask

    int n_acks = 0;

    task automatic play(input logic [3:0] c);
        cycle(1'b1, 1'b0, 1'b1, c);
        if (moveAck === 1'b1) n_acks++;
        settle();
    endtask

    initial begin
        int n;
        logic [3:0] seq_cells [9];
        reset = 1'b0; newGame = 1'b0; moveValid = 1'b0; moveCell = 4'd0;

        // Reset
        cycle(1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        check("rst_board",  32'(gBoard),     32'd0);
        check("rst_turn",   32'(turn),       32'd1);
        check("rst_ready",  32'(moveReady),  32'd1);
        check("rst_done",   32'(gameIsDone), 32'd0);
        check("rst_winner", 32'(winner),     32'd0);

        // X wins on row 0
        n_acks = 0;
        play(4'd0); play(4'd3); play(4'd1); play(4'd4); play(4'd2);
        check("win_acks",   32'(n_acks),     32'd5);
        check("win_board",  32'(gBoard),     32'(18'b00_00_00_00_10_10_01_01_01));
        check("win_winner", 32'(winner),     32'd1);
        check("win_done",   32'(gameIsDone), 32'd1);
        check("win_ready",  32'(moveReady),  32'd0);

        // DONE ignores moves
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 4'd8);
            check("done_noack", 32'(moveAck | moveErr), 32'd0);
        end
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        check("ng_ready", 32'(moveReady), 32'd1);
        check("ng_board", 32'(gBoard),    32'd0);

        // Illegal moves
        play(4'd4);
        cycle(1'b1, 1'b0, 1'b1, 4'd4);
        check("occ_err",   32'(moveErr), 32'd1);
        check("occ_turn",  32'(turn),    32'd2);
        check("occ_board", 32'(gBoard),  32'h100);
        cycle(1'b1, 1'b0, 1'b1, 4'd9);
        check("range_err", 32'(moveErr), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 4'd0);

        // Draw
        seq_cells = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
        for (int i = 0; i < 8; i++) play(seq_cells[i]);
        cycle(1'b1, 1'b0, 1'b1, seq_cells[8]);
        check("draw_ack", 32'(moveAck), 32'd1);
        n = 0;
        while (gameIsDone !== 1'b1 && n < 20) begin
            cycle(1'b1, 1'b0, 1'b0, 4'd0);
            n++;
        end
        check("draw_latency", 32'(n),      32'd8);
        check("draw_winner",  32'(winner), 32'd3);

        // newGame and reset mid-scan, with a simultaneous move request
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b1, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b1, 1'b1, 4'd5);
        check("mid_ng_board", 32'(gBoard),          32'd0);
        check("mid_ng_pulse", 32'(moveAck | moveErr), 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 4'd2);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 4'd6);
        check("mid_rst_board", 32'(gBoard),    32'd0);
        check("mid_rst_ready", 32'(moveReady), 32'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
